// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, non-key codes, decoder state encoding
// and frame geometry used by the receiver and the key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status/response bytes that never name a key
  localparam logic [7:0] PS2_NK_ERR0 = 8'h00;
  localparam logic [7:0] PS2_NK_BAT  = 8'hAA;
  localparam logic [7:0] PS2_NK_ECHO = 8'hEE;
  localparam logic [7:0] PS2_NK_ACK  = 8'hFA;
  localparam logic [7:0] PS2_NK_BATF = 8'hFC;
  localparam logic [7:0] PS2_NK_RSND = 8'hFE;
  localparam logic [7:0] PS2_NK_ERR1 = 8'hFF;

  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned FRAME_LAST = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  function automatic logic is_nonkey(input logic [7:0] b);
    return (b == PS2_NK_ERR0) || (b == PS2_NK_BAT)  || (b == PS2_NK_ECHO) ||
           (b == PS2_NK_ACK)  || (b == PS2_NK_BATF) || (b == PS2_NK_RSND) ||
           (b == PS2_NK_ERR1);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_data, detects falling edges,
// shifts in an 11-bit frame and checks start, odd parity, stop and timeout.
// Ports:
//   clk, reset_n         system clock, async active-low reset
//   i_ps2_clk/i_ps2_data raw keyboard lines
//   o_byte               received data byte (valid with o_byte_rdy)
//   o_byte_rdy           1-cycle pulse, good frame
//   o_frame_err          1-cycle pulse, bad start/parity/stop or timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_rdy,
  output logic       o_frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [8:0]             r_shift;
  logic [TO_W-1:0]        r_to_cnt;
  logic [7:0]             r_byte;
  logic                   r_byte_rdy;
  logic                   r_frame_err;

  logic w_clk_s;
  logic w_dat_s;
  logic w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Sync chains, frame shift register, bit counter and inactivity timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= '1;
      r_dat_sync  <= '1;
      r_clk_prev  <= 1'b1;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
      r_byte      <= '0;
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_clk_s;
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == '0) begin
          if (w_dat_s) r_frame_err <= 1'b1;
          else         r_bit_cnt   <= BIT_CNT_W'(1);
        end else if (r_bit_cnt == BIT_CNT_W'(FRAME_LAST)) begin
          // r_shift holds parity in [8] and d7..d0 in [7:0]
          if ((^r_shift) && w_dat_s) begin
            r_byte     <= r_shift[7:0];
            r_byte_rdy <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= {w_dat_s, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
      end else if (r_bit_cnt != '0) begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          r_frame_err <= 1'b1;
          r_bit_cnt   <= '0;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_byte      = r_byte;
  assign o_byte_rdy  = r_byte_rdy;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: decodes E0/F0-prefixed scan codes and tracks the
// single currently held key for the tone generator.
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   ps2_clk, ps2_data   raw keyboard lines
//   kb_code             last make code (held after release)
//   ken                 key kb_code currently held
//   extended            kb_code was E0-prefixed
//   key_valid/key_break 1-cycle make/break event, key_break qualifies
//   frame_err           1-cycle pulse on a dropped frame
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kb_code,
  output logic       ken,
  output logic       extended,
  output logic       key_valid,
  output logic       key_break,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_rdy;
  logic       w_rx_err;

  ps2_rx_frame #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_byte      (w_byte),
    .o_byte_rdy  (w_byte_rdy),
    .o_frame_err (w_rx_err)
  );

  dec_state_e r_state;
  logic [7:0] r_kb_code;
  logic       r_ken;
  logic       r_extended;
  logic       r_key_valid;
  logic       r_key_break;
  logic       r_frame_err;

  logic w_nonkey;
  logic w_prefix;
  logic w_ext_now;
  logic w_brk_now;

  assign w_nonkey  = is_nonkey(w_byte);
  assign w_prefix  = (w_byte == PS2_EXT) || (w_byte == PS2_BRK);
  assign w_ext_now = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_brk_now = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

  // Prefix decoder and held-key registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_kb_code   <= '0;
      r_ken       <= 1'b0;
      r_extended  <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_break <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_key_break <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_rx_err) begin
        r_frame_err <= 1'b1;
        r_state     <= ST_IDLE;
      end else if (w_byte_rdy) begin
        if (w_nonkey) begin
          r_state <= ST_IDLE;
        end else if (w_prefix) begin
          case (r_state)
            ST_IDLE: r_state <= (w_byte == PS2_EXT) ? ST_EXT : ST_BRK;
            ST_EXT:  r_state <= (w_byte == PS2_EXT) ? ST_EXT : ST_EXT_BRK;
            default: r_state <= ST_IDLE;
          endcase
        end else begin
          r_state     <= ST_IDLE;
          r_key_valid <= 1'b1;
          if (w_brk_now) begin
            r_key_break <= 1'b1;
            // Releasing a key other than the held one leaves the tone on
            if ((w_byte == r_kb_code) && (w_ext_now == r_extended))
              r_ken <= 1'b0;
          end else begin
            r_kb_code  <= w_byte;
            r_extended <= w_ext_now;
            r_ken      <= 1'b1;
          end
        end
      end
    end
  end

  assign kb_code   = r_kb_code;
  assign ken       = r_ken;
  assign extended  = r_extended;
  assign key_valid = r_key_valid;
  assign key_break = r_key_break;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus random byte
// streams compared against a behavioural held-key model.
module tb_ps2_key_tracker;

  localparam int TO_CYC = 300;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kb_code;
  logic       ken, extended, key_valid, key_break, frame_err;

  ps2_key_tracker #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kb_code   (kb_code),
    .ken       (ken),
    .extended  (extended),
    .key_valid (key_valid),
    .key_break (key_break),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_stop = 0;
  int last_kv_cyc = 0;
  int n_kv = 0, n_kb = 0, n_fe = 0, n_both = 0;

  // reference model state
  logic [7:0] m_code = 8'h00;
  bit   m_ken = 1'b0, m_ext = 1'b0;
  bit   p_ext = 1'b0, p_brk = 1'b0;
  int   e_kv = 0, e_kb = 0, e_fe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (key_valid) begin
        n_kv = n_kv + 1;
        last_kv_cyc = cyc;
        if (key_break) n_kb = n_kb + 1;
      end
      if (frame_err) n_fe = n_fe + 1;
      if (key_valid && frame_err) n_both = n_both + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit nonkey(input logic [7:0] b);
    logic [7:0] nk [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    foreach (nk[i]) if (nk[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Effect of one correctly received byte on the held-key model
  task automatic model_byte(input logic [7:0] b);
    if (nonkey(b)) begin
      p_ext = 0; p_brk = 0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (p_brk) begin
        p_ext = 0; p_brk = 0;
      end else if (b == 8'hE0) p_ext = 1;
      else p_brk = 1;
    end else begin
      e_kv = e_kv + 1;
      if (p_brk) begin
        e_kb = e_kb + 1;
        if (b == m_code && p_ext == m_ext) m_ken = 0;
      end else begin
        m_code = b; m_ext = p_ext; m_ken = 1;
      end
      p_ext = 0; p_brk = 0;
    end
  endtask

  task automatic model_err();
    e_fe = e_fe + 1;
    p_ext = 0; p_brk = 0;
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ken = 0; m_ext = 0; p_ext = 0; p_brk = 0;
  endtask

  // Drive the first nbits of an 11-bit frame; data changes while ps2_clk high
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(4);
      ps2_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      tick(4);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(b, bad_par, bad_stop, 11);
    tick(8);
    if (bad_par || bad_stop) model_err();
    else model_byte(b);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".code"}, 32'(kb_code), 32'(m_code));
    chk({tag, ".ken"},  32'(ken),     32'(m_ken));
    chk({tag, ".ext"},  32'(extended), 32'(m_ext));
    chk({tag, ".nkv"},  32'(n_kv), 32'(e_kv));
    chk({tag, ".nkb"},  32'(n_kb), 32'(e_kb));
    chk({tag, ".nfe"},  32'(n_fe), 32'(e_fe));
    chk({tag, ".both"}, 32'(n_both), 32'd0);
  endtask

  task automatic send_seq(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n);
    logic [7:0] seq [3];
    seq[0] = b0; seq[1] = b1; seq[2] = b2;
    for (int i = 0; i < n; i++) send_frame(seq[i], 1'b0, 1'b0);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] keys [6] = '{8'h1C, 8'h1B, 8'h75, 8'h2A, 8'h23, 8'h6B};
    logic [7:0] nks  [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] b;
    int r;
    bit bp, bs;

    tick(3);
    chk("rst.code", 32'(kb_code), 32'd0);
    chk("rst.ken",  32'(ken), 32'd0);
    chk("rst.ext",  32'(extended), 32'd0);
    chk("rst.kv",   32'(key_valid), 32'd0);
    chk("rst.kb",   32'(key_break), 32'd0);
    chk("rst.fe",   32'(frame_err), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // make 1C, with stop-fall to key_valid latency of two synchroniser stages + 2
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t1.lat", 32'(last_kv_cyc - t_stop), 32'd4);
    check_state("t1");
    send_seq("t2", 8'hF0, 8'h1C, 8'h00, 2);
    send_seq("t3a", 8'hE0, 8'h75, 8'h00, 2);
    send_seq("t3b", 8'hF0, 8'h75, 8'h00, 2);
    send_seq("t3c", 8'hE0, 8'hF0, 8'h75, 3);
    send_seq("t4a", 8'h1C, 8'h1B, 8'h00, 2);
    send_seq("t4b", 8'hF0, 8'h1C, 8'h00, 2);
    send_seq("t4c", 8'h1B, 8'hF0, 8'h1B, 3);
    send_seq("t4d", 8'h1B, 8'h1B, 8'h00, 2);

    send_frame(8'h1C, 1'b1, 1'b0);
    check_state("t5par");
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_state("t5stop");
    send_seq("t5nk", 8'hE0, 8'hAA, 8'h1B, 3);

    // partial frame then inactivity
    send_bits(8'h55, 1'b0, 1'b0, 5);
    tick(TO_CYC - 60);
    chk("t6.early", 32'(n_fe), 32'(e_fe));
    tick(TO_CYC + 1);
    model_err();
    check_state("t6to");
    send_seq("t6good", 8'h2A, 8'h00, 8'h00, 1);

    send_bits(8'h3C, 1'b0, 1'b0, 5);
    reset_n = 1'b0;
    tick(3);
    model_reset();
    chk("t6rst.code", 32'(kb_code), 32'd0);
    chk("t6rst.ken",  32'(ken), 32'd0);
    chk("t6rst.ext",  32'(extended), 32'd0);
    chk("t6rst.kv",   32'(key_valid), 32'd0);
    chk("t6rst.fe",   32'(frame_err), 32'd0);
    reset_n = 1'b1;
    tick(5);
    send_seq("t6post", 8'h2A, 8'h00, 8'h00, 1);

    // random byte stream with occasional corrupted frames
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r == 4) b = nks[$urandom_range(0, 6)];
      else if (r < 15) b = keys[$urandom_range(0, 5)];
      else             b = 8'($urandom);
      r  = int'($urandom_range(0, 11));
      bp = (r == 0);
      bs = (r == 1);
      send_frame(b, bp, bs);
      if (n % 4 == 3) check_state("rnd");
    end
    check_state("rnd.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
